// File: rtl/freepdk45_sram_ctrl_pkg.sv
// Shared types and constants for the freepdk45 1RW SRAM front-end controller.
package freepdk45_sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Cycles from request accept to the edge that captures dout0.
  localparam int READ_LAT = 2;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word fall-through response FIFO; a pop and a push may share an edge even when full.
module sram_rsp_fifo
  import freepdk45_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 45,
  parameter int RSP_DEPTH  = 4,
  localparam int CW = count_width(RSP_DEPTH),
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem_reg [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(RSP_DEPTH));
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/freepdk45_sram_1rw_ctrl.sv
// Valid/ready front-end for one OpenRAM 1RW port: registered macro inputs,
// post-reset clear sweep, and credit-limited read responses through a FWFT FIFO.
module freepdk45_sram_1rw_ctrl
  import freepdk45_sram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 45,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    RSP_DEPTH  = 4,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam int CW        = count_width(RSP_DEPTH);
  localparam int SW        = CW + 1;

  state_t                state_reg;
  logic [CNT_W-1:0]      init_cnt_reg;
  logic                  init_done_reg;
  logic                  csb_reg;
  logic                  web_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] din_reg;
  logic [READ_LAT-1:0]   inflight_reg;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [SW-1:0]         outstanding;
  logic                  accept;
  logic                  rsp_push;
  logic                  rsp_pop;

  // Credit: every read either sits in the FIFO or is still travelling through the macro.
  always_comb begin
    outstanding = SW'(fifo_count);
    for (int i = 0; i < READ_LAT; i++) begin
      outstanding = outstanding + SW'(inflight_reg[i]);
    end
  end

  assign req_ready = init_done_reg && (state_reg == ST_RUN) && (outstanding < SW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // The oldest in-flight bit lines up with the edge at which dout0 is still valid.
  assign rsp_push  = inflight_reg[READ_LAT-1];
  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  assign init_done  = init_done_reg;
  assign sram_csb0  = csb_reg;
  assign sram_web0  = web_reg;
  assign sram_addr0 = addr_reg;
  assign sram_din0  = din_reg;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_reg     <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
      csb_reg       <= 1'b1;
      web_reg       <= 1'b1;
      addr_reg      <= '0;
      din_reg       <= '0;
      inflight_reg  <= '0;
    end else begin
      inflight_reg <= {inflight_reg[READ_LAT-2:0], accept && !req_we};
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg == CNT_W'(RAM_DEPTH)) begin
            csb_reg       <= 1'b1;
            web_reg       <= 1'b1;
            init_done_reg <= 1'b1;
            state_reg     <= ST_RUN;
          end else begin
            csb_reg      <= 1'b0;
            web_reg      <= 1'b0;
            addr_reg     <= init_cnt_reg[ADDR_WIDTH-1:0];
            din_reg      <= INIT_VALUE;
            init_cnt_reg <= init_cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          init_done_reg <= 1'b1;
          if (accept) begin
            csb_reg  <= 1'b0;
            web_reg  <= !req_we;
            addr_reg <= req_addr;
            din_reg  <= req_wdata;
          end else begin
            csb_reg <= 1'b1;
            web_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk0),
    .srst      (rst0),
    .push      (rsp_push),
    .push_data (sram_dout0),
    .pop       (rsp_pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  push_when_full_a: assert property (@(posedge clk0) disable iff (rst0)
    !(rsp_push && fifo_full && !rsp_pop));

endmodule

// File: tb/tb_freepdk45_sram_1rw_ctrl.sv
// Bench for freepdk45_sram_1rw_ctrl: behavioural macro models, directed steps and a random phase.
module tb_freepdk45_sram_1rw_ctrl;

  localparam int DW    = 45;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          rst0, req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done;
  logic [AW-1:0] req_addr, sram_addr0;
  logic [DW-1:0] req_wdata, rsp_rdata, sram_din0, sram_dout0;
  logic          sram_csb0, sram_web0;

  logic          b_rst0, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_init_done;
  logic [AW-1:0] b_req_addr, b_sram_addr0;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata, b_sram_din0, b_sram_dout0;
  logic          b_sram_csb0, b_sram_web0;

  freepdk45_sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(4), .INIT_EN(1'b1)) dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0));

  freepdk45_sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(4), .INIT_EN(1'b0)) dut_b (
    .clk0(clk0), .rst0(b_rst0), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .init_done(b_init_done), .sram_csb0(b_sram_csb0), .sram_web0(b_sram_web0),
    .sram_addr0(b_sram_addr0), .sram_din0(b_sram_din0), .sram_dout0(b_sram_dout0));

  // Macro models: inputs sampled at posedge, array access in the low phase, dout X shortly after posedge.
  logic [DW-1:0] mac_a [DEPTH];
  logic          mq_csb_a, mq_web_a;
  logic [AW-1:0] mq_addr_a;
  logic [DW-1:0] mq_din_a;
  always @(clk0) begin
    if (clk0) begin
      mq_csb_a  <= sram_csb0;
      mq_web_a  <= sram_web0;
      mq_addr_a <= sram_addr0;
      mq_din_a  <= sram_din0;
      #1 sram_dout0 <= 'x;
    end else if (mq_csb_a === 1'b0) begin
      if (mq_web_a === 1'b0) mac_a[mq_addr_a] <= mq_din_a;
      else sram_dout0 <= mac_a[mq_addr_a];
    end
  end

  logic [DW-1:0] mac_b [DEPTH];
  logic          mq_csb_b, mq_web_b;
  logic [AW-1:0] mq_addr_b;
  logic [DW-1:0] mq_din_b;
  always @(clk0) begin
    if (clk0) begin
      mq_csb_b  <= b_sram_csb0;
      mq_web_b  <= b_sram_web0;
      mq_addr_b <= b_sram_addr0;
      mq_din_b  <= b_sram_din0;
      #1 b_sram_dout0 <= 'x;
    end else if (mq_csb_b === 1'b0) begin
      if (mq_web_b === 1'b0) mac_b[mq_addr_b] <= mq_din_b;
      else b_sram_dout0 <= mac_b[mq_addr_b];
    end
  end

  // Reference: what the array should hold, and the read data owed to the consumer in order.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0, pop_cnt = 0, cyc_no = 0, first_pop = 0, last_pop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic acc, pop;
    acc = req_valid && req_ready && !rst0;
    pop = rsp_valid && rsp_ready && !rst0;
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_rdata);
        end
      end else begin
        check("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
      end
      pop_cnt++;
      if (pop_cnt == 1) first_pop = cyc_no;
      last_pop = cyc_no;
    end
    @(posedge clk0);
    #1;
    cyc_no++;
    if (acc) begin
      acc_cnt++;
      if (req_we) ref_mem[req_addr] = req_wdata;
      else exp_q.push_back(ref_mem[req_addr]);
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = acc_cnt;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && acc_cnt == n; i++) cyc();
    check("accept", 64'(acc_cnt - n), 64'd1);
    req_valid = 1'b0;
  endtask

  // Called right after a read accept edge with an empty FIFO.
  task automatic latency(input string tag, input logic [DW-1:0] d);
    check({tag, "_k0"}, 64'(rsp_valid), 64'd0);
    cyc();
    check({tag, "_k1"}, 64'(rsp_valid), 64'd0);
    cyc();
    check({tag, "_k2"}, 64'(rsp_valid), 64'd1);
    check({tag, "_data"}, 64'(rsp_rdata), 64'(d));
  endtask

  task automatic run_init(input string tag);
    for (int n = 1; n <= DEPTH + 1; n++) begin
      cyc();
      if (n <= DEPTH)
        check(tag, 64'({sram_csb0, sram_web0, sram_addr0, init_done, req_ready, rsp_valid, sram_din0}),
              64'({2'b00, AW'(n - 1), 3'b000, DW'(0)}));
      else
        check({tag, "_done"}, 64'({sram_csb0, init_done, req_ready, rsp_valid}), 64'(4'b1110));
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] d;
    int n, w_cyc;

    rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_rst0 = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) cyc();
    check("rst_outs", 64'({req_ready, rsp_valid, init_done, sram_csb0, sram_web0}), 64'(5'b00011));
    check("rst_addr_din", 64'({sram_addr0, sram_din0}), 64'd0);

    rst0 = 1'b0;
    run_init("init");

    issue(1'b0, AW'(9'h1FF), '0);
    latency("rd_1ff", '0);
    cyc();

    d = DW'(45'h1_2345_6789A);
    issue(1'b1, AW'(9'h005), d);
    w_cyc = cyc_no;
    issue(1'b0, AW'(9'h005), '0);
    check("rd_after_wr_adjacent", 64'(cyc_no - w_cyc), 64'd1);
    latency("raw", d);
    cyc();

    for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), DW'(i));
    pop_cnt = 0;
    n = acc_cnt;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_addr = AW'(i);
      check("b2b_ready", 64'(req_ready), 64'd1);
      cyc();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10 && pop_cnt < 16; i++) cyc();
    check("b2b_accepts", 64'(acc_cnt - n), 64'd16);
    check("b2b_pops", 64'(pop_cnt), 64'd16);
    check("b2b_consecutive", 64'(last_pop - first_pop), 64'd15);

    rsp_ready = 1'b0;
    n = acc_cnt;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_addr = AW'(3 - ((acc_cnt - n) & 3));
      cyc();
    end
    check("bp_accepts", 64'(acc_cnt - n), 64'd4);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    pop_cnt = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12 && pop_cnt < 4; i++) cyc();
    check("bp_pops", 64'(pop_cnt), 64'd4);
    check("bp_ready_back", 64'(req_ready), 64'd1);
    check("bp_empty", 64'(rsp_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 31));
      req_wdata = DW'({$urandom, $urandom});
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("rand_drain", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(rsp_valid), 64'd0);

    rsp_ready = 1'b0;
    issue(1'b0, AW'(0), '0);
    issue(1'b0, AW'(1), '0);
    issue(1'b0, AW'(2), '0);
    check("pre_rst_fifo", 64'(rsp_valid), 64'd1);
    rst0 = 1'b1;
    cyc();
    exp_q.delete();
    check("mid_rst_outs", 64'({rsp_valid, sram_csb0, init_done, req_ready}), 64'(4'b0100));
    rst0 = 1'b0;
    rsp_ready = 1'b1;
    run_init("reinit");
    issue(1'b0, AW'(9'h005), '0);
    latency("post_init_rd", '0);
    pop_cnt = 0;
    for (int i = 0; i < 5 && pop_cnt < 1; i++) cyc();
    check("post_init_pop", 64'(pop_cnt), 64'd1);

    check("b_rst_outs", 64'({b_req_ready, b_init_done, b_sram_csb0, b_rsp_valid}), 64'(4'b0010));
    b_rst0 = 1'b0;
    @(posedge clk0); #1;
    check("b_ready_first_edge", 64'({b_req_ready, b_init_done}), 64'(2'b11));
    d = DW'({$urandom, $urandom});
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = AW'(9'h100); b_req_wdata = d;
    @(posedge clk0); #1;
    b_req_we = 1'b0;
    @(posedge clk0); #1;
    b_req_valid = 1'b0;
    check("b_lat_k0", 64'(b_rsp_valid), 64'd0);
    @(posedge clk0); #1;
    check("b_lat_k1", 64'(b_rsp_valid), 64'd0);
    @(posedge clk0); #1;
    check("b_lat_k2", 64'(b_rsp_valid), 64'd1);
    check("b_rd_data", 64'(b_rsp_rdata), 64'(d));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
